mem_access: RTL and testbench
=============================

Name: mem_access

Overview:
- Memory-access stage directly downstream of the ALU.
- Consumes the ALU's registered result: the effective address for LD/ST, or the final value for other operations.
- For LD/ST it runs a req/ack transaction on the data bus; for everything else it passes the value through.
- Produces the writeback value and stalls the upstream pipeline while a bus transaction is outstanding.

Parameters:
TIMEOUT_CYCLES, 255, maximum number of request cycles without dbus_ack_i before the access is aborted with bus_err_o (range 1..65535).

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
valid_i  input  1  instruction present on stage inputs this cycle
opcode_i  input  6  opcode; opcat = opcode_i[5:2]; opcode_i[1:0] = access size for LD/ST
signed_i  input  1  sign-extend load data when 1, zero-extend when 0
addr_i  input  32  ALU result: effective address (LD/ST) or result value (others)
store_data_i  input  32  store source operand, low bits significant
wb_reg_i  input  5  destination register index
ready_o  output  1  stage can accept an instruction (combinational, = state==IDLE)
dbus_req_o  output  1  bus request, held until ack or timeout
dbus_we_o  output  1  1 = write
dbus_addr_o  output  32  word-aligned address {addr[31:2],2'b00}
dbus_be_o  output  4  byte enables, bit n = byte lane n (little-endian)
dbus_wdata_o  output  32  write data replicated into lanes
dbus_ack_i  input  1  bus completion; rdata valid in same cycle
dbus_rdata_i  input  32  read data
valid_o  output  1  one-cycle pulse: writeback outputs valid
wb_en_o  output  1  register write enable, qualified by valid_o
wb_reg_o  output  5  destination register
result_o  output  32  writeback value
align_err_o  output  1  one-cycle pulse: misaligned access, no bus cycle issued
bus_err_o  output  1  one-cycle pulse: access timed out

Behaviour:
- Reset:
  - All registered outputs are 0.
  - State goes to IDLE and the timeout counter clears.
  - dbus_req_o drops asynchronously with rst_n, including mid-transaction; the pending access is discarded.
- Size encoding from opcode_i[1:0]: 00 byte, 01 half, 10 word, 11 word.
- Alignment rules:
  - Half access with addr[0]=1 is misaligned.
  - Word access with addr[1:0]!=0 is misaligned.
- FSM states: IDLE, BUS.
- IDLE, valid_i=1, opcat not LD/ST:
  - Next cycle: valid_o=1, result_o=addr_i, wb_reg_o=wb_reg_i, wb_en_o=1.
  - Latency is 1 cycle; back-to-back issue is allowed.
- IDLE, valid_i=1, LD/ST, misaligned:
  - Next cycle: align_err_o=1, valid_o=1, wb_en_o=0.
  - No request is issued and the FSM stays in IDLE.
- IDLE, valid_i=1, LD/ST, aligned:
  - Latch request; go to BUS.
  - Next cycle: dbus_req_o=1 with dbus_we_o, dbus_addr_o, dbus_be_o, dbus_wdata_o stable.
  - Byte enables: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111.
  - Write data: byte {4{d[7:0]}}, half {2{d[15:0]}}, word d.
- BUS state:
  - ready_o=0; upstream must hold its inputs, and valid_i is ignored.
  - Each cycle with dbus_ack_i=0 increments the counter.
- BUS, on dbus_ack_i=1:
  - dbus_req_o drops next cycle and the FSM returns to IDLE.
  - valid_o pulses next cycle.
  - Load: wb_en_o=1; result_o = selected lane extended per signed_i. Lanes are byte at addr[1:0]*8 and half at addr[1]*16; word is taken unmodified.
  - Store: wb_en_o=0, result_o=0.
- Timeout: if the counter reaches TIMEOUT_CYCLES without ack, next cycle:
  - dbus_req_o=0, bus_err_o=1, valid_o=1, wb_en_o=0.
  - Return to IDLE.
- Ack and timeout in the same cycle: ack wins and completes normally.
- A new instruction is accepted in the cycle the FSM is back in IDLE, i.e. the cycle valid_o pulses for the previous access.
- dbus_ack_i while not requesting is ignored.

Test Plan:
- ADD result 0x0000_1234, wb_reg 3, valid_i 1 cycle -> one cycle later valid_o=1, wb_en_o=1, result_o=0x0000_1234, wb_reg_o=3, no dbus_req_o.
- LD byte signed at 0x103, ack immediately with rdata 0x80AA_BBCC:
  - -> dbus_addr_o=0x100, be=1000, we=0; result_o=0xFFFF_FF80; valid_o exactly 2 cycles after accept.
  - Repeat with signed_i=0 -> result_o=0x0000_0080.
- ST half data 0x0000_BEEF at 0x202, ack after 3 wait cycles:
  - -> be=1100, wdata=0xBEEF_BEEF, dbus_req_o high 4 cycles, ready_o low throughout.
  - valid_o=1, wb_en_o=0.
- LD word at 0x105 -> align_err_o=1 for one cycle, valid_o=1, wb_en_o=0, dbus_req_o never asserted.
- TIMEOUT_CYCLES=4, LD word at 0x300, never ack -> dbus_req_o high 4 cycles then low, bus_err_o=1 for one cycle, wb_en_o=0, FSM accepts next instruction.
- rst_n low mid-BUS -> dbus_req_o=0 immediately, all outputs 0; after release a late dbus_ack_i produces no valid_o.

Source files
------------

// File: rtl/mem_access_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_if
//  Description : Signal bundle for the memory-access stage. It carries the
//                upstream instruction inputs, the data-bus req/ack channel
//                and the writeback outputs.
//                  slave  : seen from mem_access (drives stage outputs)
//                  master : seen from the upstream pipeline, data bus and
//                           writeback consumers (drives stage inputs)
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_if;
    // Upstream instruction inputs
    logic        valid_i;
    logic [5:0]  opcode_i;
    logic        signed_i;
    logic [31:0] addr_i;
    logic [31:0] store_data_i;
    logic [4:0]  wb_reg_i;
    logic        ready_o;
    // Data bus
    logic        dbus_req_o;
    logic        dbus_we_o;
    logic [31:0] dbus_addr_o;
    logic [3:0]  dbus_be_o;
    logic [31:0] dbus_wdata_o;
    logic        dbus_ack_i;
    logic [31:0] dbus_rdata_i;
    // Writeback
    logic        valid_o;
    logic        wb_en_o;
    logic [4:0]  wb_reg_o;
    logic [31:0] result_o;
    logic        align_err_o;
    logic        bus_err_o;

    modport slave (
        input  valid_i, opcode_i, signed_i, addr_i, store_data_i, wb_reg_i,
        input  dbus_ack_i, dbus_rdata_i,
        output ready_o, dbus_req_o, dbus_we_o, dbus_addr_o, dbus_be_o,
        output dbus_wdata_o, valid_o, wb_en_o, wb_reg_o, result_o,
        output align_err_o, bus_err_o
    );

    modport master (
        output valid_i, opcode_i, signed_i, addr_i, store_data_i, wb_reg_i,
        output dbus_ack_i, dbus_rdata_i,
        input  ready_o, dbus_req_o, dbus_we_o, dbus_addr_o, dbus_be_o,
        input  dbus_wdata_o, valid_o, wb_en_o, wb_reg_o, result_o,
        input  align_err_o, bus_err_o
    );
endinterface
`default_nettype wire

// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access
//  Description : Memory-access pipeline stage sitting after the ALU.
//                LD/ST run one req/ack transaction on the data bus. All other
//                operations pass the ALU result through to writeback after
//                one cycle. Upstream is stalled (ready_o=0) while a bus
//                access is outstanding.
//                Opcode categories (opcode_i[5:2]): 4'h8 = LD, 4'h9 = ST.
//                Access size (opcode_i[1:0]): 00 byte, 01 half, 1x word.
//  Ports       : clk, rst_n (async, active low)
//                ma : mem_access_if.slave - instruction in, data bus,
//                     writeback out
//  Parameters  : TIMEOUT_CYCLES - request cycles without ack before the
//                access is aborted with bus_err_o (1..65535)
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    mem_access_if.slave   ma
);

    localparam logic [3:0]  c_OPCAT_LD  = 4'h8;
    localparam logic [3:0]  c_OPCAT_ST  = 4'h9;
    // A timeout fires in the request cycle where the count of earlier
    // ack-less cycles equals TIMEOUT_CYCLES-1, so dbus_req_o is high for
    // exactly TIMEOUT_CYCLES cycles.
    localparam logic [15:0] c_CNT_LAST  = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUS  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [15:0] r_cnt;
    logic        r_req;
    logic        r_we;
    logic [31:0] r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [1:0]  r_lane;
    logic [1:0]  r_size;
    logic        r_signed;
    logic        r_is_ld;
    logic [4:0]  r_pend_reg;

    logic        r_valid;
    logic        r_wb_en;
    logic [4:0]  r_wb_reg;
    logic [31:0] r_result;
    logic        r_align_err;
    logic        r_bus_err;

    // ------------------------------------------------------------------
    // Instruction decode
    // ------------------------------------------------------------------
    logic [3:0]  w_opcat;
    logic [1:0]  w_size;
    logic        w_is_ld;
    logic        w_is_st;
    logic        w_misalign;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;

    assign w_opcat    = ma.opcode_i[5:2];
    assign w_size     = ma.opcode_i[1:0];
    assign w_is_ld    = (w_opcat == c_OPCAT_LD);
    assign w_is_st    = (w_opcat == c_OPCAT_ST);
    assign w_misalign = ((w_size == 2'b01) && ma.addr_i[0]) ||
                        (w_size[1] && (ma.addr_i[1:0] != 2'b00));

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = ma.store_data_i;
        case (w_size)
            2'b00: begin
                w_be    = 4'b0001 << ma.addr_i[1:0];
                w_wdata = {4{ma.store_data_i[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << ma.addr_i[1:0];
                w_wdata = {2{ma.store_data_i[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = ma.store_data_i;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Load-data lane selection and extension (uses the latched access)
    // ------------------------------------------------------------------
    logic [7:0]  w_rd_byte;
    logic [15:0] w_rd_half;
    logic [31:0] w_load;

    assign w_rd_byte = ma.dbus_rdata_i[{r_lane, 3'b000} +: 8];
    assign w_rd_half = ma.dbus_rdata_i[{r_lane[1], 4'b0000} +: 16];

    always_comb begin
        w_load = ma.dbus_rdata_i;
        case (r_size)
            2'b00:   w_load = {{24{r_signed & w_rd_byte[7]}}, w_rd_byte};
            2'b01:   w_load = {{16{r_signed & w_rd_half[15]}}, w_rd_half};
            default: w_load = ma.dbus_rdata_i;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM next-state and event decode
    // ------------------------------------------------------------------
    logic w_acc_pass;
    logic w_acc_align;
    logic w_acc_bus;
    logic w_ack_done;
    logic w_timeout;

    always_comb begin
        w_state_nxt = r_state;
        w_acc_pass  = 1'b0;
        w_acc_align = 1'b0;
        w_acc_bus   = 1'b0;
        w_ack_done  = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ma.valid_i) begin
                    if (!(w_is_ld || w_is_st)) begin
                        w_acc_pass = 1'b1;
                    end else if (w_misalign) begin
                        w_acc_align = 1'b1;
                    end else begin
                        w_acc_bus   = 1'b1;
                        w_state_nxt = S_BUS;
                    end
                end
            end
            S_BUS: begin
                // Ack takes priority over a timeout in the same cycle.
                if (ma.dbus_ack_i) begin
                    w_ack_done  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 16'd0;
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= 32'd0;
            r_be        <= 4'd0;
            r_wdata     <= 32'd0;
            r_lane      <= 2'd0;
            r_size      <= 2'd0;
            r_signed    <= 1'b0;
            r_is_ld     <= 1'b0;
            r_pend_reg  <= 5'd0;
            r_valid     <= 1'b0;
            r_wb_en     <= 1'b0;
            r_wb_reg    <= 5'd0;
            r_result    <= 32'd0;
            r_align_err <= 1'b0;
            r_bus_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_valid     <= 1'b0;
            r_wb_en     <= 1'b0;
            r_align_err <= 1'b0;
            r_bus_err   <= 1'b0;

            if (w_acc_pass) begin
                r_valid  <= 1'b1;
                r_wb_en  <= 1'b1;
                r_wb_reg <= ma.wb_reg_i;
                r_result <= ma.addr_i;
            end

            if (w_acc_align) begin
                r_valid     <= 1'b1;
                r_align_err <= 1'b1;
                r_wb_reg    <= ma.wb_reg_i;
                r_result    <= 32'd0;
            end

            if (w_acc_bus) begin
                r_req      <= 1'b1;
                r_we       <= w_is_st;
                r_addr     <= {ma.addr_i[31:2], 2'b00};
                r_be       <= w_be;
                r_wdata    <= w_wdata;
                r_lane     <= ma.addr_i[1:0];
                r_size     <= w_size;
                r_signed   <= ma.signed_i;
                r_is_ld    <= w_is_ld;
                r_pend_reg <= ma.wb_reg_i;
                r_cnt      <= 16'd0;
            end

            if (w_ack_done) begin
                r_req    <= 1'b0;
                r_valid  <= 1'b1;
                r_wb_en  <= r_is_ld;
                r_wb_reg <= r_pend_reg;
                r_result <= r_is_ld ? w_load : 32'd0;
            end else if (w_timeout) begin
                r_req     <= 1'b0;
                r_valid   <= 1'b1;
                r_bus_err <= 1'b1;
                r_wb_reg  <= r_pend_reg;
                r_result  <= 32'd0;
            end else if (r_state == S_BUS) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    assign ma.ready_o      = (r_state == S_IDLE);
    assign ma.dbus_req_o   = r_req;
    assign ma.dbus_we_o    = r_we;
    assign ma.dbus_addr_o  = r_addr;
    assign ma.dbus_be_o    = r_be;
    assign ma.dbus_wdata_o = r_wdata;
    assign ma.valid_o      = r_valid;
    assign ma.wb_en_o      = r_wb_en;
    assign ma.wb_reg_o     = r_wb_reg;
    assign ma.result_o     = r_result;
    assign ma.align_err_o  = r_align_err;
    assign ma.bus_err_o    = r_bus_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access
//  Description : Self-checking bench for mem_access. Each instruction is
//                turned into an expected per-cycle output timeline (keyed by
//                absolute cycle number) computed from byte-level arithmetic;
//                one compare process checks the DUT against it every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access;

    localparam int         TO       = 4;
    localparam logic [3:0] OPCAT_LD = 4'h8;
    localparam logic [3:0] OPCAT_ST = 4'h9;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_access_if mif();

    mem_access #(.TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ma    (mif)
    );

    typedef struct {
        bit          valid, wb_en, align_err, bus_err, req, ready;
        bit          chk_bus, chk_res, we, lit_en;
        logic [4:0]  wb_reg;
        logic [31:0] result, addr, wdata, lit_res;
        logic [3:0]  be;
    } snap_t;

    snap_t exp_q [int];
    int    cyc    = 0;
    int    total  = 0;
    int    bad    = 0;
    bit    chk_on = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, expv);
        end
    endtask

    function automatic snap_t idle_snap();
        snap_t s;
        s = '{default: '0};
        s.ready = 1'b1;
        return s;
    endfunction

    // ---------------- behavioural model ----------------
    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] lo, input logic [1:0] sz);
        logic [3:0] b;
        int nb = nbytes(sz);
        for (int n = 0; n < 4; n++) b[n] = (n >= int'(lo)) && (n < int'(lo) + nb);
        return b;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] d, input logic [1:0] sz);
        logic [31:0] w;
        int nb = nbytes(sz);
        for (int n = 0; n < 4; n++) w[8*n +: 8] = d[8*(n % nb) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [1:0] sz,
                                               input logic [1:0] lo, input bit sgn);
        int nb    = nbytes(sz);
        int bits  = 8 * nb;
        int start = (nb == 1) ? int'(lo) : (nb == 2) ? (int'(lo) / 2) * 2 : 0;
        longint v = longint'({32'd0, rd}) >> (8 * start);
        v = v & ((longint'(1) << bits) - 1);
        if (sgn && (((v >> (bits - 1)) & 1) == 1)) v = v - (longint'(1) << bits);
        return v[31:0];
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        snap_t s;
        if (rst_n === 1'b1 && chk_on) begin
            if (exp_q.exists(cyc)) begin
                s = exp_q[cyc];
                exp_q.delete(cyc);
            end else begin
                s = idle_snap();
            end
            chk("ready_o", 32'(mif.ready_o), 32'(s.ready));
            chk("dbus_req_o", 32'(mif.dbus_req_o), 32'(s.req));
            chk("valid_o", 32'(mif.valid_o), 32'(s.valid));
            chk("align_err_o", 32'(mif.align_err_o), 32'(s.align_err));
            chk("bus_err_o", 32'(mif.bus_err_o), 32'(s.bus_err));
            if (s.valid) chk("wb_en_o", 32'(mif.wb_en_o), 32'(s.wb_en));
            if (s.valid && s.wb_en) chk("wb_reg_o", 32'(mif.wb_reg_o), 32'(s.wb_reg));
            if (s.valid && s.chk_res) chk("result_o", mif.result_o, s.result);
            if (s.valid && s.lit_en) chk("result_lit", mif.result_o, s.lit_res);
            if (s.chk_bus) begin
                chk("dbus_we_o", 32'(mif.dbus_we_o), 32'(s.we));
                chk("dbus_addr_o", mif.dbus_addr_o, s.addr);
                chk("dbus_be_o", 32'(mif.dbus_be_o), 32'(s.be));
                chk("dbus_wdata_o", mif.dbus_wdata_o, s.wdata);
            end
        end
    end

    // ---------------- stimulus ----------------
    // Called at #1 after a rising edge with the DUT ready; returns at #1
    // after the edge that starts the writeback pulse cycle (DUT ready again).
    // d = wait cycles before ack (d >= TO means no ack).
    task automatic run_instr(input logic [3:0] opcat, input logic [1:0] sz, input bit sgn,
                             input logic [31:0] addr, input logic [31:0] data,
                             input logic [4:0] wr, input int d, input logic [31:0] rdata,
                             input bit lit_en = 1'b0, input logic [31:0] lit_res = 32'd0,
                             input bit lit_bus = 1'b0, input logic [3:0] lit_be = 4'd0,
                             input logic [31:0] lit_addr = 32'd0,
                             input logic [31:0] lit_wd = 32'd0);
        snap_t s;
        int    base  = cyc;
        bit    is_ld = (opcat == OPCAT_LD);
        bit    is_mem = is_ld || (opcat == OPCAT_ST);
        int    nb    = nbytes(sz);
        bit    mis   = (nb == 2 && addr[0]) || (nb == 4 && addr[1:0] != 2'b00);
        bit    tmo   = (d >= TO);
        int    nreq  = tmo ? TO : d + 1;
        bit    hold  = 1'($urandom_range(0, 1));

        mif.valid_i      = 1'b1;
        mif.opcode_i     = {opcat, sz};
        mif.signed_i     = sgn;
        mif.addr_i       = addr;
        mif.store_data_i = data;
        mif.wb_reg_i     = wr;

        s = idle_snap();
        s.valid  = 1'b1;
        s.wb_reg = wr;
        s.lit_en = lit_en;
        s.lit_res = lit_res;
        if (!is_mem) begin
            s.wb_en = 1'b1; s.chk_res = 1'b1; s.result = addr;
            exp_q[base + 1] = s;
        end else if (mis) begin
            s.align_err = 1'b1;
            exp_q[base + 1] = s;
        end else begin
            s.wb_en   = is_ld && !tmo;
            s.bus_err = tmo;
            s.chk_res = !tmo;
            s.result  = is_ld ? model_load(rdata, sz, addr[1:0], sgn) : 32'd0;
            exp_q[base + 1 + nreq] = s;
            for (int k = 0; k < nreq; k++) begin
                snap_t r = idle_snap();
                r.ready = 1'b0; r.req = 1'b1; r.chk_bus = 1'b1; r.we = !is_ld;
                r.addr  = {addr[31:2], 2'b00};
                r.be    = model_be(addr[1:0], sz);
                r.wdata = model_wdata(data, sz);
                exp_q[base + 1 + k] = r;
            end
        end

        @(posedge clk); #1;
        mif.valid_i = 1'b0;
        if (is_mem && !mis) begin
            if (lit_bus) begin
                chk("lit_be", 32'(mif.dbus_be_o), 32'(lit_be));
                chk("lit_addr", mif.dbus_addr_o, lit_addr);
                chk("lit_wdata", mif.dbus_wdata_o, lit_wd);
            end
            for (int k = 0; k < nreq; k++) begin
                // Upstream may keep presenting its held instruction; it must be ignored.
                mif.valid_i = hold;
                if (!tmo && k == d) begin
                    mif.dbus_ack_i   = 1'b1;
                    mif.dbus_rdata_i = rdata;
                end
                @(posedge clk); #1;
                mif.dbus_ack_i   = 1'b0;
                mif.dbus_rdata_i = $urandom;
                mif.valid_i      = 1'b0;
            end
        end
    endtask

    // Idle cycles with stray acks, which must be ignored.
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            mif.dbus_ack_i   = 1'($urandom_range(0, 1));
            mif.dbus_rdata_i = $urandom;
            @(posedge clk); #1;
            mif.dbus_ack_i = 1'b0;
        end
    endtask

    initial begin
        logic [3:0] op;
        rst_n            = 1'b0;
        mif.valid_i      = 1'b0;
        mif.opcode_i     = 6'd0;
        mif.signed_i     = 1'b0;
        mif.addr_i       = 32'd0;
        mif.store_data_i = 32'd0;
        mif.wb_reg_i     = 5'd0;
        mif.dbus_ack_i   = 1'b0;
        mif.dbus_rdata_i = 32'd0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(mif.ready_o), 32'd1);
        chk("rst_req", 32'(mif.dbus_req_o), 32'd0);
        chk("rst_valid", 32'(mif.valid_o), 32'd0);
        chk("rst_result", mif.result_o, 32'd0);
        chk("rst_be", 32'(mif.dbus_be_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_on = 1'b1;

        // Directed cases with hand-computed expectations
        run_instr(4'h0, 2'b00, 1'b0, 32'h0000_1234, 32'd0, 5'd3, 0, 32'd0,
                  1'b1, 32'h0000_1234);
        idle_cycles(1);
        run_instr(OPCAT_LD, 2'b00, 1'b1, 32'h0000_0103, 32'd0, 5'd4, 0, 32'h80AA_BBCC,
                  1'b1, 32'hFFFF_FF80, 1'b1, 4'b1000, 32'h0000_0100, 32'h0000_0000);
        run_instr(OPCAT_LD, 2'b00, 1'b0, 32'h0000_0103, 32'd0, 5'd4, 0, 32'h80AA_BBCC,
                  1'b1, 32'h0000_0080);
        run_instr(OPCAT_ST, 2'b01, 1'b0, 32'h0000_0202, 32'h0000_BEEF, 5'd5, 3, 32'd0,
                  1'b1, 32'h0000_0000, 1'b1, 4'b1100, 32'h0000_0200, 32'hBEEF_BEEF);
        run_instr(OPCAT_LD, 2'b10, 1'b0, 32'h0000_0105, 32'd0, 5'd6, 0, 32'd0);
        run_instr(OPCAT_LD, 2'b10, 1'b0, 32'h0000_0300, 32'd0, 5'd7, 100, 32'd0);
        run_instr(OPCAT_LD, 2'b01, 1'b1, 32'h0000_0402, 32'd0, 5'd8, 3, 32'h8001_7FFF,
                  1'b1, 32'hFFFF_8001);
        run_instr(4'h2, 2'b11, 1'b0, 32'hDEAD_BEEF, 32'd0, 5'd9, 0, 32'd0,
                  1'b1, 32'hDEAD_BEEF);
        idle_cycles(2);

        // Randomized traffic
        for (int i = 0; i < 250; i++) begin
            int r = $urandom_range(0, 9);
            if (r < 4)      op = OPCAT_LD;
            else if (r < 7) op = OPCAT_ST;
            else begin
                do op = 4'($urandom_range(0, 15)); while (op == OPCAT_LD || op == OPCAT_ST);
            end
            run_instr(op, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom,
                      $urandom, 5'($urandom_range(0, 31)), $urandom_range(0, 5), $urandom);
            if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 2));
        end
        idle_cycles(2);

        // Reset in the middle of a bus access
        chk_on = 1'b0;
        mif.valid_i  = 1'b1;
        mif.opcode_i = {OPCAT_LD, 2'b10};
        mif.addr_i   = 32'h0000_0400;
        @(posedge clk); #1;
        mif.valid_i = 1'b0;
        chk("pre_rst_req", 32'(mif.dbus_req_o), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", 32'(mif.dbus_req_o), 32'd0);
        chk("mid_rst_valid", 32'(mif.valid_o), 32'd0);
        chk("mid_rst_addr", mif.dbus_addr_o, 32'd0);
        chk("mid_rst_be", 32'(mif.dbus_be_o), 32'd0);
        chk("mid_rst_ready", 32'(mif.ready_o), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        chk_on = 1'b1;
        mif.dbus_ack_i   = 1'b1;
        mif.dbus_rdata_i = 32'h1234_5678;
        @(posedge clk); #1;
        mif.dbus_ack_i = 1'b0;
        idle_cycles(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
